// File: rtl/grid_writer.sv
// Cell-state storage for the game board: single-cell set/increment writes over
// valid/ready, plus a one-cell-per-clock fill sweep of the whole board.
module grid_writer #(
  parameter int unsigned SIZE_X    = 10,
  parameter int unsigned SIZE_Y    = 10,
  parameter int unsigned CELL_BITS = 1,
  parameter int unsigned XBITS     = $clog2(SIZE_X),
  parameter int unsigned YBITS     = $clog2(SIZE_Y),
  parameter int unsigned GDBITS    = CELL_BITS * SIZE_X * SIZE_Y
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [XBITS-1:0]     wr_x,
  input  logic [YBITS-1:0]     wr_y,
  input  logic                 wr_op,
  input  logic [CELL_BITS-1:0] wr_type,
  input  logic                 clr_start,
  input  logic [CELL_BITS-1:0] clr_type,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [GDBITS-1:0]    data
);

  localparam int unsigned NCELLS = SIZE_X * SIZE_Y;
  localparam int unsigned CBITS  = $clog2(NCELLS);
  localparam int unsigned OBITS  = $clog2(GDBITS);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t               state_q, state_d;
  logic [CBITS-1:0]     cnt_q, cnt_d;
  logic [CELL_BITS-1:0] fill_q, fill_d;
  logic [GDBITS-1:0]    data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 wr_fire;
  logic                 wr_in_range;
  logic [OBITS-1:0]     wr_off;
  logic [OBITS-1:0]     clr_off;
  logic [CELL_BITS-1:0] cur_cell;

  assign wr_ready    = (state_q == IDLE) & ~clr_start;
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = (32'(wr_x) < SIZE_X) && (32'(wr_y) < SIZE_Y);
  // Offsets are only used for in-range writes, so truncation is harmless.
  assign wr_off      = OBITS'((32'(wr_y) * SIZE_X + 32'(wr_x)) * CELL_BITS);
  assign clr_off     = OBITS'(32'(cnt_q) * CELL_BITS);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cur_cell = '0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          fill_d  = clr_type;
          cnt_d   = '0;
          state_d = CLEAR;
        end else if (wr_fire) begin
          if (wr_in_range) begin
            cur_cell = data_q[wr_off +: CELL_BITS];
            data_d[wr_off +: CELL_BITS] = wr_op ? cur_cell + CELL_BITS'(1) : wr_type;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        data_d[clr_off +: CELL_BITS] = fill_q;
        if (cnt_q == CBITS'(NCELLS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign data = data_q;

endmodule

// File: tb/tb_grid_writer.sv
// Self-checking bench for grid_writer: a per-cell array model of the board
// predicts data/err/done/busy under directed and random stimulus.
module tb_grid_writer;

  logic        clk, rst;
  logic        wr_valid, wr_op, clr_start;
  logic [3:0]  wr_x, wr_y;
  logic [0:0]  wr_type, clr_type;
  logic        wr_ready, busy, done, err;
  logic [99:0] data;

  logic        w2_valid, w2_op, c2_start;
  logic [3:0]  w2_x, w2_y;
  logic [1:0]  w2_type, c2_type;
  logic        r2_ready, b2, d2, e2;
  logic [199:0] data2;

  int unsigned model [100];
  int nvec = 0;
  int nerr = 0;

  grid_writer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_op(wr_op), .wr_type(wr_type),
    .clr_start(clr_start), .clr_type(clr_type),
    .busy(busy), .done(done), .err(err), .data(data)
  );

  grid_writer #(.CELL_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .wr_valid(w2_valid), .wr_ready(r2_ready),
    .wr_x(w2_x), .wr_y(w2_y), .wr_op(w2_op), .wr_type(w2_type),
    .clr_start(c2_start), .clr_type(c2_type),
    .busy(b2), .done(d2), .err(e2), .data(data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [99:0] exp_data();
    logic [99:0] v;
    for (int i = 0; i < 100; i++) v[i] = model[i][0];
    return v;
  endfunction

  task automatic model_clear(input int unsigned val);
    for (int i = 0; i < 100; i++) model[i] = val;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 0; wr_op = 0; clr_start = 0; wr_x = 0; wr_y = 0; wr_type = 0; clr_type = 0;
    w2_valid = 0; w2_op = 0; c2_start = 0; w2_x = 0; w2_y = 0; w2_type = 0; c2_type = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear(0);
    nvec++; if (data !== '0) begin nerr++; $display("FAIL reset_data got %h want 0", data); end
    nvec++; if ({busy, done, err} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
    nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b want 1", wr_ready); end
  endtask

  task automatic test_set_default();
    wr_valid = 1; wr_x = 3; wr_y = 2; wr_op = 0; wr_type = 1;
    @(posedge clk); #1;
    wr_valid = 0;
    model[23] = 1;
    nvec++; if (data !== exp_data()) begin nerr++; $display("FAIL set_3_2 got %h want %h", data, exp_data()); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL set_err got %b want 0", err); end
  endtask

  task automatic test_out_of_range();
    logic [3:0] xs [2];
    logic [3:0] ys [2];
    xs[0] = 10; ys[0] = 0; xs[1] = 0; ys[1] = 15;
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1; wr_x = xs[k]; wr_y = ys[k]; wr_op = 0; wr_type = 1;
      @(posedge clk); #1;
      wr_valid = 0;
      nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL oob_err_%0d got %b want 1", k, err); end
      nvec++; if (data !== exp_data()) begin nerr++; $display("FAIL oob_data_%0d got %h want %h", k, data, exp_data()); end
      @(posedge clk); #1;
      nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL oob_err_len_%0d got %b want 0", k, err); end
    end
  endtask

  task automatic test_random_writes();
    int unsigned x, y, op, ty, idle;
    bit exp_err;
    for (int n = 0; n < 300; n++) begin
      idle = $urandom_range(0, 4);
      x  = $urandom_range(0, 11);
      y  = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 10);
      op = $urandom_range(0, 1);
      ty = $urandom_range(0, 1);
      wr_valid = (idle != 0);
      wr_x = 4'(x); wr_y = 4'(y); wr_op = op[0]; wr_type = ty[0];
      #1;
      nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL rnd_ready_%0d got %b want 1", n, wr_ready); end
      @(posedge clk); #1;
      exp_err = 0;
      if (idle != 0) begin
        if (x < 10 && y < 10) model[y*10+x] = op ? (model[y*10+x] + 1) % 2 : ty;
        else exp_err = 1;
      end
      nvec++; if (data !== exp_data()) begin nerr++; $display("FAIL rnd_data_%0d got %h want %h", n, data, exp_data()); end
      nvec++; if (err !== exp_err) begin nerr++; $display("FAIL rnd_err_%0d got %b want %b", n, err, exp_err); end
    end
    wr_valid = 0;
  endtask

  task automatic test_incr_wrap();
    logic [1:0] seq [3];
    seq[0] = 3; seq[1] = 0; seq[2] = 1;
    for (int k = 0; k < 3; k++) begin
      w2_valid = 1; w2_x = 1; w2_y = 0; w2_op = (k != 0); w2_type = 3;
      @(posedge clk); #1;
      w2_valid = 0;
      nvec++; if (data2[3:2] !== seq[k]) begin nerr++; $display("FAIL incr_wrap_%0d got %0d want %0d", k, data2[3:2], seq[k]); end
      nvec++; if ({data2[199:4], data2[1:0]} !== '0) begin nerr++; $display("FAIL incr_others_%0d got %h want 0", k, data2); end
    end
  endtask

  task automatic test_clear_hold_write();
    int cnt = 0;
    bit ready_bad = 0;
    clr_start = 1; clr_type = 1;
    @(posedge clk); #1;
    clr_start = 0; clr_type = 0;
    wr_valid = 1; wr_x = 5; wr_y = 5; wr_op = 0; wr_type = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (wr_ready !== 1'b0) ready_bad = 1;
      @(posedge clk); #1;
    end
    model_clear(1);
    nvec++; if (cnt !== 100) begin nerr++; $display("FAIL clr_busy_len got %0d want 100", cnt); end
    nvec++; if (ready_bad) begin nerr++; $display("FAIL clr_ready_low got 1 want 0"); end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL clr_done got %b want 1", done); end
    nvec++; if (data !== exp_data()) begin nerr++; $display("FAIL clr_data got %h want %h", data, exp_data()); end
    nvec++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL clr_ready_after got %b want 1", wr_ready); end
    @(posedge clk); #1;
    wr_valid = 0;
    model[55] = 0;
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL clr_done_len got %b want 0", done); end
    nvec++; if (data !== exp_data()) begin nerr++; $display("FAIL clr_held_write got %h want %h", data, exp_data()); end
  endtask

  task automatic test_clear_vs_write();
    int cnt = 0;
    clr_start = 1; clr_type = 0;
    wr_valid = 1; wr_x = 2; wr_y = 3; wr_op = 0; wr_type = 1;
    #1;
    nvec++; if (wr_ready !== 1'b0) begin nerr++; $display("FAIL cvw_ready got %b want 0", wr_ready); end
    @(posedge clk); #1;
    clr_start = 0;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL cvw_busy got %b want 1", busy); end
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    model_clear(0);
    nvec++; if (data !== exp_data() || done !== 1'b1) begin nerr++; $display("FAIL cvw_sweep got %h done %b want %h done 1", data, done, exp_data()); end
    @(posedge clk); #1;
    wr_valid = 0;
    model[32] = 1;
    nvec++; if (data !== exp_data()) begin nerr++; $display("FAIL cvw_write_after got %h want %h", data, exp_data()); end
  endtask

  task automatic test_reset_mid_sweep();
    bit bad = 0;
    logic [99:0] e;
    clr_start = 1; clr_type = 1;
    @(posedge clk); #1;
    clr_start = 0;
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_clear(0);
    nvec++; if (data !== '0) begin nerr++; $display("FAIL rmid_data got %h want 0", data); end
    nvec++; if ({busy, done, err} !== 3'b000) begin nerr++; $display("FAIL rmid_flags got %b want 000", {busy, done, err}); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    nvec++; if (bad) begin nerr++; $display("FAIL rmid_no_resume got 1 want 0"); end
    wr_valid = 1; wr_x = 7; wr_y = 9; wr_op = 1; wr_type = 0;
    @(posedge clk); #1;
    wr_valid = 0;
    e = '0; e[97] = 1'b1;
    nvec++; if (data !== e) begin nerr++; $display("FAIL rmid_write got %h want %h", data, e); end
  endtask

  initial begin
    test_reset();
    test_set_default();
    test_out_of_range();
    test_random_writes();
    test_incr_wrap();
    test_clear_hold_write();
    test_clear_vs_write();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/grid_writer.md
Name: grid_writer

Overview:
Owns the cell-state storage for a SIZE_X x SIZE_Y board and drives the flattened `data` bus that the grid lookup block reads. Accepts single-cell write requests (set or increment) over a valid/ready handshake and performs a fill-clear sweep of the whole board at one cell per clock. Sits between game/control logic, which issues cell updates from clicks or rules, and the pixel-side grid lookup, which consumes `data`.

Parameters:
SIZE_X, 8'd10, cells per row
SIZE_Y, 8'd10, cells per column
CELL_BITS, 4'd1, bits per cell type
XBITS, $clog2(SIZE_X), cell x index width
YBITS, $clog2(SIZE_Y), cell y index width
GDBITS, CELL_BITS*SIZE_X*SIZE_Y, flattened storage width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
wr_valid  in  1  write request valid
wr_ready  out  1  write request accepted this cycle when high with wr_valid
wr_x  in  XBITS  target cell column
wr_y  in  YBITS  target cell row
wr_op  in  1  0 = set cell to wr_type, 1 = increment cell modulo 2^CELL_BITS
wr_type  in  CELL_BITS  value for set op (ignored for increment)
clr_start  in  1  request full-board fill
clr_type  in  CELL_BITS  fill value, sampled with clr_start
busy  out  1  fill sweep in progress
done  out  1  one-cycle pulse after last fill write
err  out  1  one-cycle pulse: accepted write was out of range
data  out  GDBITS  board storage, cell (x,y) at bit offset (y*SIZE_X+x)*CELL_BITS, width CELL_BITS

Behaviour:
- Reset (async, any time, including mid-sweep): data all zero, state IDLE, busy=0, done=0, err=0, sweep counter 0, latched fill value 0. A sweep in progress is aborted, not resumed.
- States: IDLE, CLEAR. busy = (state==CLEAR), registered.
- wr_ready = (state==IDLE) & ~clr_start (combinational). A write is accepted on an edge where wr_valid & wr_ready.
- Accepted write, wr_x<SIZE_X and wr_y<SIZE_Y: target cell updated on the same edge, visible on data in the next cycle. Set: cell<=wr_type. Increment: cell<=cell+1, truncated to CELL_BITS (max wraps to 0). Other cells unchanged.
- Accepted write out of range (wr_x>=SIZE_X or wr_y>=SIZE_Y): data unchanged; err=1 for exactly the following cycle.
- Unaccepted wr_valid (busy or clr_start high) is ignored. Requester holds the request until wr_ready.
- IDLE & clr_start on an edge: latch clr_type, counter<=0, state<=CLEAR. clr_start wins over a simultaneous wr_valid; the write is not accepted.
- CLEAR: each edge writes the latched fill value to linear cell index = counter, then counter+1. On the edge writing index SIZE_X*SIZE_Y-1: state<=IDLE, done<=1 for one cycle. busy is high for exactly SIZE_X*SIZE_Y cycles.
- clr_start while busy is ignored. clr_type changes after the start edge have no effect.
- Counter width is $clog2(SIZE_X*SIZE_Y) and never exceeds SIZE_X*SIZE_Y-1.
- err and done are registered, default 0, and are never high at the same time as each other's trigger cycle ambiguity. Each pulses only as defined above.

Test Plan:
- Defaults: after reset, data==0. Accept set (x=3,y=2,type=1), so data[23]=1 next cycle, all other bits 0, and err stays 0.
- CELL_BITS=2: set (1,0)=3, then increment (1,0). data[3:2] goes 3 -> 0. A further increment gives 1.
- Write x=10,y=0 (defaults): err pulses for 1 cycle and data is unchanged. Write y=15 gives the same result.
- clr_start with clr_type=1 (defaults): busy is high for 100 cycles and wr_ready=0 throughout. done pulses 1 cycle later and data is all ones. A wr_valid held during the sweep is accepted on the first IDLE cycle.
- clr_start and wr_valid on the same edge: wr_ready=0, the sweep starts, and the write lands only after done.
- Assert rst 40 cycles into a fill with clr_type=1: data=0, busy=0, and done never pulses. A new write after rst is released works normally.
